// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, EX/MEM pipeline register.
// Define MUL_EN to add a 33-stall-cycle shift-add multiplier for op 9.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_rs1_val,
  input  logic [31:0] id_rs2_val,
  input  logic [31:0] id_imm,
  input  logic        id_alu_src,
  input  logic [3:0]  id_alu_op,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_valid,
  input  logic [1:0]  forward_a,
  input  logic [1:0]  forward_b,
  input  logic [31:0] ex_mem_fwd_data,
  input  logic [31:0] mem_wb_fwd_data,
  input  logic        flush,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_store_data,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_reg_write,
  output logic        ex_mem_mem_read,
  output logic        ex_mem_mem_write,
  output logic        ex_mem_valid,
  output logic        ex_stall
);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpSlt = 4'd5;
  localparam logic [3:0] OpSll = 4'd6;
  localparam logic [3:0] OpSrl = 4'd7;
  localparam logic [3:0] OpSra = 4'd8;
`ifdef MUL_EN
  localparam logic [3:0] OpMul = 4'd9;
`endif

  logic [31:0] w_op_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_res;
  logic [31:0] w_result;
  logic        w_stall_raw;

  // Code 2'b11 is unused by the hazard unit and falls back to the register file.
  always_comb begin
    case (forward_a)
      2'b01:   w_op_a = mem_wb_fwd_data;
      2'b10:   w_op_a = ex_mem_fwd_data;
      default: w_op_a = id_rs1_val;
    endcase
  end

  always_comb begin
    case (forward_b)
      2'b01:   w_fwd_b = mem_wb_fwd_data;
      2'b10:   w_fwd_b = ex_mem_fwd_data;
      default: w_fwd_b = id_rs2_val;
    endcase
  end

  assign w_op_b = id_alu_src ? id_imm : w_fwd_b;

  always_comb begin
    w_alu_res = 32'd0;
    case (id_alu_op)
      OpAdd:   w_alu_res = w_op_a + w_op_b;
      OpSub:   w_alu_res = w_op_a - w_op_b;
      OpAnd:   w_alu_res = w_op_a & w_op_b;
      OpOr:    w_alu_res = w_op_a | w_op_b;
      OpXor:   w_alu_res = w_op_a ^ w_op_b;
      OpSlt:   w_alu_res = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
      OpSll:   w_alu_res = w_op_a << w_op_b[4:0];
      OpSrl:   w_alu_res = w_op_a >> w_op_b[4:0];
      OpSra:   w_alu_res = $unsigned($signed(w_op_a) >>> w_op_b[4:0]);
      default: w_alu_res = 32'd0;
    endcase
  end

`ifdef MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

  mul_state_e  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_prod;
  logic        w_mul_issue;

  assign w_mul_issue = (r_state == StIdle) && id_valid && (id_alu_op == OpMul);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= 5'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_prod   <= 32'd0;
    end else if (flush) begin
      r_state <= StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_mul_issue) begin
            r_mcand  <= w_op_a;
            r_mplier <= w_fwd_b;
            r_prod   <= 32'd0;
            r_cnt    <= 5'd0;
            r_state  <= StBusy;
          end
        end
        StBusy: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= StDone;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_stall_raw = (r_state == StBusy) || w_mul_issue;
  // The ID/EX fields are still held from issue, so only the result is swapped in.
  assign w_result    = (r_state == StDone) ? r_prod : w_alu_res;
`else
  assign w_stall_raw = 1'b0;
  assign w_result    = w_alu_res;
`endif

  assign ex_stall = rst_n & ~flush & w_stall_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_alu_result <= 32'd0;
      ex_mem_store_data <= 32'd0;
      ex_mem_rd         <= 5'd0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_valid      <= 1'b0;
    end else if (flush || ex_stall || !id_valid) begin
      ex_mem_alu_result <= 32'd0;
      ex_mem_store_data <= 32'd0;
      ex_mem_rd         <= 5'd0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_valid      <= 1'b0;
    end else begin
      ex_mem_alu_result <= w_result;
      ex_mem_store_data <= w_fwd_b;
      ex_mem_rd         <= id_rd;
      ex_mem_reg_write  <= id_reg_write;
      ex_mem_mem_read   <= id_mem_read;
      ex_mem_mem_write  <= id_mem_write;
      ex_mem_valid      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; multiplier checks are built only when MUL_EN is defined.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write, id_valid;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] ex_mem_fwd_data, mem_wb_fwd_data;
  logic        flush;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_valid;
  logic        ex_stall;

  int total = 0;
  int bad   = 0;

  ex_stage u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1_val        (id_rs1_val),
    .id_rs2_val        (id_rs2_val),
    .id_imm            (id_imm),
    .id_alu_src        (id_alu_src),
    .id_alu_op         (id_alu_op),
    .id_rd             (id_rd),
    .id_reg_write      (id_reg_write),
    .id_mem_read       (id_mem_read),
    .id_mem_write      (id_mem_write),
    .id_valid          (id_valid),
    .forward_a         (forward_a),
    .forward_b         (forward_b),
    .ex_mem_fwd_data   (ex_mem_fwd_data),
    .mem_wb_fwd_data   (mem_wb_fwd_data),
    .flush             (flush),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_valid      (ex_mem_valid),
    .ex_stall          (ex_stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1_val = '0; id_rs2_val = '0; id_imm = '0; id_alu_src = 1'b0;
    id_alu_op = '0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_mem_write = 1'b0; id_valid = 1'b0; forward_a = 2'b00; forward_b = 2'b00;
    ex_mem_fwd_data = '0; mem_wb_fwd_data = '0; flush = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    idle_inputs();
    id_alu_op = op; id_rs1_val = a; id_rs2_val = b; id_rd = rd;
    id_reg_write = 1'b1; id_valid = 1'b1;
  endtask

  localparam int NVec = 12;
  logic [3:0]  v_op  [NVec] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6,
                                4'd7, 4'd8, 4'd1, 4'd0, 4'd12, 4'd15};
  logic [31:0] v_a   [NVec] = '{32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_FFFE,
                                32'h1, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'd5,
                                32'hFFFF_FFFF, 32'd5, 32'd5};
  logic [31:0] v_b   [NVec] = '{32'h0FF0_FF00, 32'h0000_000F, 32'h0F0F_0F0F, 32'h1,
                                32'hFFFF_FFFE, 32'd33, 32'd4, 32'd4, 32'd7, 32'd2,
                                32'd3, 32'd3};
  logic [31:0] v_exp [NVec] = '{32'h00F0_1200, 32'hF000_000F, 32'hF0F0_0F0F, 32'h1,
                                32'h0, 32'h2, 32'h0800_0000, 32'hF800_0000,
                                32'hFFFF_FFFE, 32'h1, 32'h0, 32'h0};

  initial begin
    int n;
    int vbad;
    rst_n = 1'b0;
    idle_inputs();
    #2;
    check_eq("rst_result", ex_mem_alu_result, 32'd0);
    check_eq("rst_store", ex_mem_store_data, 32'd0);
    check_eq("rst_ctrl", {27'd0, ex_mem_rd}, 32'd0);
    check_eq("rst_flags", {28'd0, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
                           ex_mem_valid}, 32'd0);
    issue(4'd9, 32'd3, 32'd4, 5'd1);
    #1;
    check_eq("rst_stall", {31'd0, ex_stall}, 32'd0);
    idle_inputs();
    #5;
    rst_n = 1'b1;
    tick();

    // ADD with EX/MEM forwarding on A
    issue(4'd0, 32'd99, 32'd7, 5'd3);
    forward_a = 2'b10; ex_mem_fwd_data = 32'd5;
    check_eq("add_stall", {31'd0, ex_stall}, 32'd0);
    tick();
    check_eq("add_fwd_result", ex_mem_alu_result, 32'd12);
    check_eq("add_rd", {27'd0, ex_mem_rd}, 32'd3);
    check_eq("add_flags", {28'd0, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
                           ex_mem_valid}, 32'b1001);

    issue(4'd1, 32'd0, 32'd55, 5'd4);
    forward_b = 2'b01; mem_wb_fwd_data = 32'd1;
    tick();
    check_eq("sub_fwd_b", ex_mem_alu_result, 32'hFFFF_FFFF);
    check_eq("sub_store", ex_mem_store_data, 32'd1);

    issue(4'd1, 32'd10, 32'd3, 5'd4);
    forward_a = 2'b11; forward_b = 2'b11;
    ex_mem_fwd_data = 32'd100; mem_wb_fwd_data = 32'd200;
    tick();
    check_eq("fwd11_as_00", ex_mem_alu_result, 32'd7);

    // SW: address from rs1+imm, store data from forwarded B
    issue(4'd0, 32'h100, 32'h55, 5'd0);
    id_reg_write = 1'b0; id_mem_write = 1'b1; id_alu_src = 1'b1; id_imm = 32'd8;
    forward_b = 2'b10; ex_mem_fwd_data = 32'hAB;
    tick();
    check_eq("sw_addr", ex_mem_alu_result, 32'h108);
    check_eq("sw_store", ex_mem_store_data, 32'hAB);
    check_eq("sw_flags", {28'd0, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
                          ex_mem_valid}, 32'b0011);

    for (int i = 0; i < NVec; i++) begin
      issue(v_op[i], v_a[i], v_b[i], 5'd2);
      tick();
      check_eq($sformatf("alu_vec%0d_op%0d", i, v_op[i]), ex_mem_alu_result, v_exp[i]);
    end

    issue(4'd0, 32'd1, 32'd1, 5'd4);
    id_valid = 1'b0;
    tick();
    check_eq("invalid_bubble", {ex_mem_alu_result[26:0], ex_mem_rd}, 32'd0);
    check_eq("invalid_flags", {28'd0, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
                               ex_mem_valid}, 32'd0);

    issue(4'd0, 32'd1, 32'd1, 5'd4);
    flush = 1'b1;
    #1;
    check_eq("flush_stall", {31'd0, ex_stall}, 32'd0);
    tick();
    check_eq("flush_bubble", {ex_mem_alu_result[30:0], ex_mem_valid}, 32'd0);

    // Asynchronous reset clears a loaded result between edges
    issue(4'd0, 32'd1, 32'd1, 5'd5);
    tick();
    check_eq("pre_rst_result", ex_mem_alu_result, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_result", ex_mem_alu_result, 32'd0);
    check_eq("async_rst_valid", {27'd0, ex_mem_rd}, {31'd0, ex_mem_valid});
    check_eq("async_rst_rd", {27'd0, ex_mem_rd}, 32'd0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef MUL_EN
    issue(4'd9, 32'h0000_FFFF, 32'h0001_0001, 5'd7);
    n = 0;
    vbad = 0;
    while (ex_stall && n < 60) begin
      n++;
      tick();
      if (ex_mem_valid) vbad++;
    end
    check_eq("mul_stall_cycles", n, 32'd33);
    check_eq("mul_valid_during_stall", vbad, 32'd0);
    tick();
    check_eq("mul_result", ex_mem_alu_result, 32'hFFFF_FFFF);
    check_eq("mul_valid", {31'd0, ex_mem_valid}, 32'd1);
    check_eq("mul_rd", {27'd0, ex_mem_rd}, 32'd7);
    idle_inputs();
    tick();

    issue(4'd9, 32'd3, 32'd4, 5'd7);
    repeat (10) tick();
    check_eq("busy10_stall", {31'd0, ex_stall}, 32'd1);
    flush = 1'b1;
    #1;
    check_eq("mul_flush_stall", {31'd0, ex_stall}, 32'd0);
    tick();
    check_eq("mul_flush_bubble", {31'd0, ex_mem_valid}, 32'd0);
    issue(4'd0, 32'd2, 32'd3, 5'd8);
    #1;
    check_eq("post_flush_idle", {31'd0, ex_stall}, 32'd0);
    tick();
    check_eq("post_flush_add", ex_mem_alu_result, 32'd5);
    check_eq("post_flush_valid", {31'd0, ex_mem_valid}, 32'd1);

    issue(4'd9, 32'h0000_FFFF, 32'h0001_0001, 5'd7);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_mul_stall", {31'd0, ex_stall}, 32'd0);
    id_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    issue(4'd0, 32'd4, 32'd4, 5'd9);
    #1;
    check_eq("rst_mul_aborted", {31'd0, ex_stall}, 32'd0);
    tick();
    check_eq("rst_then_add", ex_mem_alu_result, 32'd8);
    idle_inputs();
    vbad = 0;
    repeat (40) begin
      tick();
      if (ex_mem_valid || ex_mem_alu_result == 32'hFFFF_FFFF) vbad++;
    end
    check_eq("no_late_mul", vbad, 32'd0);
`else
    issue(4'd9, 32'd3, 32'd4, 5'd6);
    #1;
    check_eq("op9_no_stall", {31'd0, ex_stall}, 32'd0);
    tick();
    check_eq("op9_result", ex_mem_alu_result, 32'd0);
    check_eq("op9_valid", {31'd0, ex_mem_valid}, 32'd1);
    issue(4'd0, 32'd1, 32'd2, 5'd6);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_op_result", ex_mem_alu_result, 32'd0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    vbad = 0;
    repeat (5) begin
      tick();
      if (ex_mem_valid) vbad++;
    end
    check_eq("no_late_result", vbad, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
